// File: rtl/pulse_gen_pkg.sv
// ---------------------------------------------------------------------------
// pulse_gen_pkg : shared types and constants for the button/pulse stages
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESS   = 2'b01,
    HOLD    = 2'b10,
    RELEASE = 2'b11
  } btn_state_t;

  // Button vectors are ordered {dwn, up}
  localparam logic [1:0] BTN_NONE = 2'b00;
  localparam logic [1:0] BTN_UP   = 2'b01;
  localparam logic [1:0] BTN_DWN  = 2'b10;
  localparam logic [1:0] BTN_BOTH = 2'b11;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_step_ctrl_if.sv
// ---------------------------------------------------------------------------
// btn_step_ctrl_if : enable/button inputs and step/held outputs of the
//                    button conditioner
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface btn_step_ctrl_if;
  logic en_i;
  logic up_i;
  logic dwn_i;
  logic step_up_o;
  logic step_dwn_o;
  logic held_o;

  modport master (
    output en_i, up_i, dwn_i,
    input  step_up_o, step_dwn_o, held_o
  );

  modport slave (
    input  en_i, up_i, dwn_i,
    output step_up_o, step_dwn_o, held_o
  );
endinterface

`default_nettype wire

// File: rtl/btn_sync.sv
// ---------------------------------------------------------------------------
// btn_sync : NUM_SYNC-deep reset-to-zero synchronizer for one raw button
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module btn_sync #(
  parameter int NUM_SYNC = 2
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic d_i,
  output logic q_o
);

  logic [NUM_SYNC-1:0] sync_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) sync_q <= '0;
    else          sync_q <= {sync_q[NUM_SYNC-2:0], d_i};
  end

  assign q_o = sync_q[NUM_SYNC-1];

endmodule

`default_nettype wire

// File: rtl/btn_step_ctrl.sv
// ---------------------------------------------------------------------------
// btn_step_ctrl : debounced up/down buttons -> single-cycle step pulses.
// Define BTN_AUTOREPEAT_EN to add auto-repeat pulses while a button is held.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module btn_step_ctrl
  import pulse_gen_pkg::*;
#(
  parameter int NUM_SYNC      = 2,
  parameter int DEBOUNCE      = 50000,
  parameter bit BTN_ACTIVE    = 1'b1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  btn_step_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE, REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic       up_pol, dwn_pol, up_s, dwn_s;
  logic [1:0] btn;

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lat_q, lat_d;
  logic             step_up_q, step_up_d, step_dwn_q, step_dwn_d;
  logic             fire;

  assign up_pol  = BTN_ACTIVE ? bus.up_i  : ~bus.up_i;
  assign dwn_pol = BTN_ACTIVE ? bus.dwn_i : ~bus.dwn_i;

  btn_sync #(.NUM_SYNC(NUM_SYNC)) u_sync_up  (.clk_i(clk_i), .arstn_i(arstn_i), .d_i(up_pol),  .q_o(up_s));
  btn_sync #(.NUM_SYNC(NUM_SYNC)) u_sync_dwn (.clk_i(clk_i), .arstn_i(arstn_i), .d_i(dwn_pol), .q_o(dwn_s));

  assign btn = {dwn_s, up_s};

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DLY_C = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_C = CNT_W'(REPEAT_PERIOD - 1);
  logic rpt_q, rpt_d, rpt_hit;
  // First repeat waits the long delay, later ones use the shorter period
  assign rpt_hit = rpt_q ? (cnt_q == PER_C) : (cnt_q == DLY_C);
`endif

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lat_q      <= BTN_NONE;
      step_up_q  <= 1'b0;
      step_dwn_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rpt_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_q      <= lat_d;
      step_up_q  <= step_up_d;
      step_dwn_q <= step_dwn_d;
`ifdef BTN_AUTOREPEAT_EN
      rpt_q      <= rpt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
`ifdef BTN_AUTOREPEAT_EN
    rpt_d   = rpt_q;
`endif
    if (!bus.en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      lat_d   = BTN_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (btn != BTN_NONE) begin
            lat_d   = btn;
            state_d = PRESS;
          end
        end
        PRESS: begin
          if (btn != lat_q) begin
            cnt_d = '0;
            lat_d = btn;
            if (btn == BTN_NONE) state_d = IDLE;
          end else if (cnt_q == DEB_C) begin
            cnt_d   = '0;
            state_d = HOLD;
`ifdef BTN_AUTOREPEAT_EN
            rpt_d   = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
        HOLD: begin
          // Any change of the pressed set, including adding a button, is a release
          if (btn != lat_q) begin
            cnt_d   = '0;
            state_d = RELEASE;
          end else begin
`ifdef BTN_AUTOREPEAT_EN
            if (lat_q != BTN_BOTH) begin
              if (rpt_hit) begin
                cnt_d = '0;
                rpt_d = 1'b1;
              end else begin
                cnt_d = cnt_q + ONE_C;
              end
            end
`else
            cnt_d = '0;
`endif
          end
        end
        RELEASE: begin
          if (btn != BTN_NONE) begin
            cnt_d = '0;
          end else if (cnt_q == DEB_C) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    fire = 1'b0;
    if (bus.en_i && (btn == lat_q)) begin
      if ((state_q == PRESS) && (cnt_q == DEB_C)) fire = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
      if ((state_q == HOLD) && rpt_hit) fire = 1'b1;
`endif
    end
    step_up_d  = fire && (lat_q == BTN_UP);
    step_dwn_d = fire && (lat_q == BTN_DWN);
  end

  assign bus.step_up_o  = step_up_q;
  assign bus.step_dwn_o = step_dwn_q;
  assign bus.held_o     = (state_q == HOLD);

endmodule

`default_nettype wire

// File: tb/tb_btn_step_ctrl.sv
// ---------------------------------------------------------------------------
// tb_btn_step_ctrl : directed + random stimulus against a press/hold/quiet
// reference model of the button conditioner
// ---------------------------------------------------------------------------
`default_nettype none

module tb_btn_step_ctrl;

  localparam int NUM_SYNC      = 2;
  localparam int DEBOUNCE      = 4;
  localparam int REPEAT_DELAY  = 10;
  localparam int REPEAT_PERIOD = 5;
  localparam int M_WAIT  = 0;
  localparam int M_HELD  = 1;
  localparam int M_QUIET = 2;

  logic clk_i   = 1'b0;
  logic arstn_i = 1'b0;

  btn_step_ctrl_if bus();

  btn_step_ctrl #(
    .NUM_SYNC(NUM_SYNC), .DEBOUNCE(DEBOUNCE), .BTN_ACTIVE(1'b1),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) dut (
    .clk_i(clk_i),
    .arstn_i(arstn_i),
    .bus(bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: sample stream -> wait / held / quiet phases
  logic [1:0] m_dly [NUM_SYNC];
  int         m_mode, m_run, m_age, m_zero;
  logic [1:0] m_runv, m_lat;
  logic       m_up, m_dn, m_held;
  int         cyc = 0;

  int n_up, n_dn, first_up, first_dn, a_cyc;

  task automatic model_reset();
    for (int i = 0; i < NUM_SYNC; i++) m_dly[i] = 2'b00;
    m_mode = M_WAIT; m_run = 0; m_age = 0; m_zero = 0;
    m_runv = 2'b00; m_lat = 2'b00;
    m_up = 1'b0; m_dn = 1'b0; m_held = 1'b0;
  endtask

  task automatic model_step();
    logic [1:0] b;
    b = m_dly[NUM_SYNC-1];
    for (int i = NUM_SYNC-1; i > 0; i--) m_dly[i] = m_dly[i-1];
    m_dly[0] = {bus.dwn_i, bus.up_i};
    cyc++;
    m_up = 1'b0;
    m_dn = 1'b0;
    if (!bus.en_i) begin
      m_mode = M_WAIT;
      m_run  = 0;
    end else begin
      case (m_mode)
        M_WAIT: begin
          if (b == 2'b00) m_run = 0;
          else if (m_run > 0 && b == m_runv) m_run++;
          else begin m_runv = b; m_run = 1; end
          // Needs the latching sample plus DEBOUNCE+1 more identical samples
          if (m_run == DEBOUNCE + 2) begin
            m_up = (b == 2'b01);
            m_dn = (b == 2'b10);
            m_mode = M_HELD; m_lat = b; m_age = 0;
          end
        end
        M_HELD: begin
          if (b != m_lat) begin
            m_mode = M_QUIET; m_zero = 0;
          end else begin
            m_age++;
`ifdef BTN_AUTOREPEAT_EN
            if (m_age >= REPEAT_DELAY && ((m_age - REPEAT_DELAY) % REPEAT_PERIOD) == 0) begin
              m_up = (m_lat == 2'b01);
              m_dn = (m_lat == 2'b10);
            end
`endif
          end
        end
        default: begin
          if (b == 2'b00) m_zero++;
          else            m_zero = 0;
          if (m_zero == DEBOUNCE + 1) begin m_mode = M_WAIT; m_run = 0; end
        end
      endcase
    end
    m_held = (m_mode == M_HELD);
  endtask

  task automatic compare();
    check_val("step_up",  bus.step_up_o,  m_up);
    check_val("step_dwn", bus.step_dwn_o, m_dn);
    check_val("held",     bus.held_o,     m_held);
    if (bus.step_up_o === 1'b1) begin n_up++; if (first_up < 0) first_up = cyc; end
    if (bus.step_dwn_o === 1'b1) begin n_dn++; if (first_dn < 0) first_dn = cyc; end
  endtask

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      model_step();
      @(negedge clk_i);
      compare();
    end
  endtask

  task automatic mark();
    a_cyc = cyc; n_up = 0; n_dn = 0; first_up = -1; first_dn = -1;
  endtask

  int exp_rep;

  initial begin
`ifdef BTN_AUTOREPEAT_EN
    exp_rep = 6;
`else
    exp_rep = 1;
`endif
    bus.en_i = 1'b1; bus.up_i = 1'b0; bus.dwn_i = 1'b0;
    model_reset();
    mark();
    #1;
    check_val("rst_step_up",  bus.step_up_o,  0);
    check_val("rst_step_dwn", bus.step_dwn_o, 0);
    check_val("rst_held",     bus.held_o,     0);
    @(negedge clk_i);
    @(negedge clk_i);
    arstn_i = 1'b1;
    cycle(5);

    // Clean press of 40 cycles
    mark(); bus.up_i = 1'b1; cycle(40); bus.up_i = 1'b0; cycle(12);
    check_val("clean_n_up",  n_up, exp_rep);
    check_val("clean_n_dwn", n_dn, 0);
    check_val("clean_lat",   first_up - a_cyc - 1, NUM_SYNC + DEBOUNCE + 1);

    // Bouncing down button, then a stable press
    mark();
    for (int k = 0; k < 5; k++) begin
      bus.dwn_i = 1'b1; cycle(3); bus.dwn_i = 1'b0; cycle(3);
    end
    check_val("bounce_quiet", n_dn + n_up, 0);
    mark(); bus.dwn_i = 1'b1; cycle(14); bus.dwn_i = 1'b0;
    check_val("bounce_n_dwn", n_dn, 1);
    check_val("bounce_lat",   first_dn - a_cyc - 1, NUM_SYNC + DEBOUNCE + 1);
    cycle(12);

    // Simultaneous press, then a normal up press after the quiet window
    mark(); bus.up_i = 1'b1; bus.dwn_i = 1'b1; cycle(30);
    check_val("simul_held",   bus.held_o, 1);
    check_val("simul_pulses", n_up + n_dn, 0);
    bus.up_i = 1'b0; bus.dwn_i = 1'b0; cycle(8);
    mark(); bus.up_i = 1'b1; cycle(12); bus.up_i = 1'b0;
    check_val("after_simul_n_up", n_up, 1);
    check_val("after_simul_lat",  first_up - a_cyc - 1, NUM_SYNC + DEBOUNCE + 1);
    cycle(12);

    // Asynchronous reset while held, button still pressed on release
    bus.up_i = 1'b1; cycle(10);
    #2 arstn_i = 1'b0;
    #1;
    check_val("arst_held",     bus.held_o,     0);
    check_val("arst_step_up",  bus.step_up_o,  0);
    check_val("arst_step_dwn", bus.step_dwn_o, 0);
    model_reset();
    @(negedge clk_i);
    arstn_i = 1'b1;
    mark(); cycle(12);
    check_val("arst_n_up", n_up, 1);
    check_val("arst_lat",  first_up - a_cyc - 1, NUM_SYNC + DEBOUNCE + 1);
    bus.up_i = 1'b0; cycle(12);

    // Enable drop during a held down press
    bus.dwn_i = 1'b1; cycle(10);
    bus.en_i = 1'b0; cycle(1);
    check_val("endrop_held", bus.held_o, 0);
    cycle(2);
    bus.en_i = 1'b1; mark(); cycle(12);
    check_val("enrise_n_dwn", n_dn, 1);
    check_val("enrise_lat",   first_dn - a_cyc - 1, DEBOUNCE + 1);
    bus.dwn_i = 1'b0; cycle(12);

    // Random button patterns with occasional enable drops
    for (int k = 0; k < 150; k++) begin
      logic [1:0] pat;
      int len;
      pat = 2'($urandom_range(0, 3));
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(15, 40)) : int'($urandom_range(1, 8));
      bus.up_i  = pat[0];
      bus.dwn_i = pat[1];
      bus.en_i  = ($urandom_range(0, 19) != 0);
      cycle(len);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/btn_step_ctrl.md
# btn_step_ctrl

Button conditioner feeding the frequency-step inputs of the LED sweep/blink stage. It synchronizes and debounces the raw up/down push-buttons and emits single-cycle step pulses. With the compile option enabled, a held button also produces auto-repeat pulses. The outputs connect directly to the blink stage's freq_up_i/freq_dwn_i.

## Interface
- NUM_SYNC, 2: synchronizer flops per button (≥2)
- DEBOUNCE, 50000: stable cycles required on press and on release (≥1)
- BTN_ACTIVE, 1: 1 = buttons active-high, 0 = active-low
- REPEAT_DELAY, 25000000: held cycles before first auto-repeat pulse (≥2)
- REPEAT_PERIOD, 5000000: cycles between subsequent repeat pulses (≥2)
- clk_i  in  1  clock
- arstn_i  in  1  reset, asynchronous, active-low
- en_i  in  1  conditioner enable; low forces IDLE
- up_i  in  1  raw up button (asynchronous)
- dwn_i  in  1  raw down button (asynchronous)
- step_up_o  out  1  one-cycle up-step pulse
- step_dwn_o  out  1  one-cycle down-step pulse
- held_o  out  1  high while a debounced press is held (HOLD state)

## Operation
- Inputs are polarity-normalized by BTN_ACTIVE, then passed through an NUM_SYNC-stage synchronizer. Synchronizers run regardless of en_i. Sampled vector btn = {dwn_s, up_s}.
- A single shared counter cnt has width $clog2(max(DEBOUNCE,REPEAT_DELAY,REPEAT_PERIOD)+1). It saturates at no value; every path clears it explicitly.
- FSM states: IDLE, PRESS, HOLD, RELEASE.
- IDLE: btn==00 → cnt=0. btn!=00 → latch btn into lat, cnt=0, go to PRESS.
- PRESS: btn!=lat → cnt=0, lat=btn, and stay in PRESS; if btn==00, return to IDLE. Otherwise cnt++. When cnt==DEBOUNCE: pulse step_up_o if lat==01, pulse step_dwn_o if lat==10, no pulse if lat==11. Then cnt=0 and go to HOLD.
- HOLD: held_o=1. If btn!=lat → cnt=0 and go to RELEASE. Otherwise run the repeat logic (Configuration).
- RELEASE: btn!=00 → cnt=0. btn==00 → cnt++. At cnt==DEBOUNCE → cnt=0 and go to IDLE.
- A simultaneous press (lat==11) never produces pulses, including repeats. A second button added or removed during HOLD counts as release.
- en_i low: next cycle state=IDLE, cnt=0, lat=00, all outputs 0. A press held when en_i rises goes through a full PRESS debounce.
- The step outputs are never both high in the same cycle.

## Timing
- Reset values: step_up_o=0, step_dwn_o=0, held_o=0, state=IDLE, cnt=0, lat=00, synchronizers 0 (post-polarity).
- Press latency: a raw input asserted stably before edge 0 produces its pulse in the cycle after edge NUM_SYNC+DEBOUNCE+1. held_o rises on that same cycle.
- Pulse width is exactly 1 cycle, registered outputs.
- Release: held_o falls the cycle after the synchronized release is seen. A new press is accepted only after DEBOUNCE+1 consecutive idle samples.
- Glitch rejection: any btn change within the debounce window restarts the count. A glitch shorter than DEBOUNCE+1 cycles after sync never pulses.

## Configuration
- BTN_AUTOREPEAT_EN defined: in HOLD with lat==01 or 10, cnt increments each cycle.
  - When cnt==REPEAT_DELAY-1, emit a pulse in the latched direction and set cnt=0.
  - From then on, emit a pulse and set cnt=0 each time cnt==REPEAT_PERIOD-1.
  - A repeat flag register selects which limit applies; it is cleared on HOLD entry.
- BTN_AUTOREPEAT_EN undefined: HOLD only watches for release, cnt stays 0, and exactly one pulse is emitted per press. The repeat flag and REPEAT_* comparisons are not synthesized. The parameters are accepted but ignored.

## Structure
- Shared package pulse_gen_pkg holds:
  - btn_state_t encoding (IDLE=2'b00, PRESS=2'b01, HOLD=2'b10, RELEASE=2'b11)
  - btn direction constants (BTN_UP=2'b01, BTN_DWN=2'b10, BTN_BOTH=2'b11)
- Sub-module btn_sync: parameterized NUM_SYNC-deep reset-to-zero flop chain, instantiated once per button.

## Test plan
Bench parameters: NUM_SYNC=2, DEBOUNCE=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
- Reset: assert arstn_i mid-HOLD → all outputs 0 immediately, state IDLE. After release of reset, up_i already held → one step_up_o 7 cycles later.
- Clean press: up_i high for 40 cycles, macro off → exactly one step_up_o pulse at cycle 7 after assertion, held_o high cycles 7–42, and no pulses on step_dwn_o.
- Bounce: dwn_i toggles with 3-cycle highs ×5, then stays high → no pulse during the bounce; one step_dwn_o 7 cycles after the final rise.
- Simultaneous: up_i and dwn_i high together for 30 cycles → zero pulses on either output, held_o high. After release plus 5 idle cycles, an up press pulses normally.
- Auto-repeat (macro on): up_i held 40 cycles → pulses at cycles 7, 17, 22, 27, 32, 37 after assertion, none after release.
- Enable drop: en_i low during HOLD with dwn_i held → held_o 0 next cycle. When en_i rises again, step_dwn_o follows after 5 cycles of PRESS debounce.
